// File: rtl/serial_link_word_packer.sv
// Packs a serial byte stream little-endian into 32-bit words and pushes each
// word, or a flushed partial word, to the mailbox as a single OBI write.
module serial_link_word_packer #(
  parameter int                    DATA_WIDTH = 32,
  parameter int                    ADDR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] MBOX_ADDR  = '0,
  parameter int                    CNT_WIDTH  = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  byte_valid_i,
  output logic                  byte_ready_o,
  input  logic [7:0]            byte_data_i,
  input  logic                  flush_i,
  output logic                  writer_req_o,
  input  logic                  writer_gnt_i,
  input  logic                  writer_rvalid_i,
  output logic [ADDR_WIDTH-1:0] writer_addr_o,
  output logic                  writer_we_o,
  output logic [3:0]            writer_be_o,
  output logic [DATA_WIDTH-1:0] writer_wdata_o,
  output logic [CNT_WIDTH-1:0]  words_sent_o,
  output logic                  busy_o
);

  typedef enum logic {FILL, REQ} state_e;

  state_e                state_q, state_d;
  logic [1:0]            idx_q, idx_d;
  logic [DATA_WIDTH-1:0] word_q, word_d;
  logic [3:0]            be_q, be_d;
  logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;

  // Writes are fire-and-forget; the response channel carries nothing we need.
  logic unused_rvalid;
  assign unused_rvalid = writer_rvalid_i;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= FILL;
      idx_q   <= 2'd0;
      word_q  <= '0;
      be_q    <= 4'h0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      word_q  <= word_d;
      be_q    <= be_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    word_d       = word_q;
    be_d         = be_q;
    cnt_d        = cnt_q;
    byte_ready_o = 1'b0;
    writer_req_o = 1'b0;
    unique case (state_q)
      FILL: begin
        byte_ready_o = 1'b1;
        if (byte_valid_i) begin
          word_d[{idx_q, 3'b000} +: 8] = byte_data_i;
          be_d[idx_q]                  = 1'b1;
          idx_d                        = idx_q + 2'd1;
        end
        // The byte (if any) lands first, so a same-cycle flush includes it.
        if ((byte_valid_i && idx_q == 2'd3) ||
            (flush_i && (byte_valid_i || idx_q != 2'd0))) begin
          state_d = REQ;
          idx_d   = 2'd0;
        end
      end
      REQ: begin
        writer_req_o = 1'b1;
        if (writer_gnt_i) begin
          cnt_d   = cnt_q + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
          word_d  = '0;
          be_d    = 4'h0;
          state_d = FILL;
        end
      end
      default: state_d = FILL;
    endcase
  end

  assign writer_addr_o  = MBOX_ADDR;
  assign writer_we_o    = 1'b1;
  assign writer_be_o    = be_q;
  assign writer_wdata_o = word_q;
  assign words_sent_o   = cnt_q;
  assign busy_o         = (state_q == REQ) || (idx_q != 2'd0);

endmodule

// File: tb/tb_serial_link_word_packer.sv
// Directed bench for the word packer; a second instance with a 2-bit counter
// shares all inputs so counter wrap is reachable in a few words.
module tb_serial_link_word_packer;

  logic        clk = 1'b0;
  logic        rst_n, bv, fl, gnt, rv;
  logic [7:0]  bd;
  logic        ready, req, we, ready_n, req_n, we_n, busy, busy_n;
  logic [31:0] addr, wdata, addr_n, wdata_n;
  logic [3:0]  be, be_n;
  logic [15:0] ws;
  logic [1:0]  ws_n;
  int tests = 0;
  int errors = 0;

  always #5 clk = ~clk;

  serial_link_word_packer dut (
    .clk_i(clk), .rst_ni(rst_n), .byte_valid_i(bv), .byte_ready_o(ready),
    .byte_data_i(bd), .flush_i(fl), .writer_req_o(req), .writer_gnt_i(gnt),
    .writer_rvalid_i(rv), .writer_addr_o(addr), .writer_we_o(we),
    .writer_be_o(be), .writer_wdata_o(wdata), .words_sent_o(ws), .busy_o(busy)
  );

  serial_link_word_packer #(.CNT_WIDTH(2)) dut_n (
    .clk_i(clk), .rst_ni(rst_n), .byte_valid_i(bv), .byte_ready_o(ready_n),
    .byte_data_i(bd), .flush_i(fl), .writer_req_o(req_n), .writer_gnt_i(gnt),
    .writer_rvalid_i(rv), .writer_addr_o(addr_n), .writer_we_o(we_n),
    .writer_be_o(be_n), .writer_wdata_o(wdata_n), .words_sent_o(ws_n), .busy_o(busy_n)
  );

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic put(input logic [7:0] b);
    bv = 1'b1; bd = b; tick(); bv = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; bv = 1'b0; bd = 8'h00; fl = 1'b0; gnt = 1'b0; rv = 1'b0;
    tick(); tick(); rst_n = 1'b1;
    tests++; if ({ready, req, be, busy} !== {1'b1, 1'b0, 4'h0, 1'b0}) begin errors++; $display("FAIL reset_ctrl got rdy=%b req=%b be=%h busy=%b want 1 0 0 0", ready, req, be, busy); end
    tests++; if (wdata !== 32'h0 || ws !== 16'h0) begin errors++; $display("FAIL reset_data got wdata=%h ws=%h want 0 0", wdata, ws); end
    tests++; if (addr !== 32'h0 || we !== 1'b1) begin errors++; $display("FAIL addr_we got addr=%h we=%b want 0 1", addr, we); end
  endtask

  task automatic test_full_word();
    logic [7:0] b [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
    gnt = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tests++; if (ready !== 1'b1 || req !== 1'b0) begin errors++; $display("FAIL full_fill%0d got rdy=%b req=%b want 1 0", i, ready, req); end
      put(b[i]);
    end
    tests++; if ({req, ready} !== 2'b10) begin errors++; $display("FAIL full_req got req=%b rdy=%b want 1 0", req, ready); end
    tests++; if (wdata !== 32'h44332211 || be !== 4'hF) begin errors++; $display("FAIL full_word got %h be=%h want 44332211 f", wdata, be); end
    tick();
    tests++; if ({req, ready, busy} !== 3'b010) begin errors++; $display("FAIL full_after got req=%b rdy=%b busy=%b want 0 1 0", req, ready, busy); end
    tests++; if (ws !== 16'd1 || ws_n !== 2'd1) begin errors++; $display("FAIL full_cnt got %0d/%0d want 1/1", ws, ws_n); end
  endtask

  task automatic test_flush_partial();
    gnt = 1'b0;
    put(8'hAA); put(8'hBB);
    tests++; if (busy !== 1'b1 || req !== 1'b0) begin errors++; $display("FAIL part_fill got busy=%b req=%b want 1 0", busy, req); end
    fl = 1'b1; tick(); fl = 1'b0;
    tests++; if (req !== 1'b1 || wdata !== 32'h0000BBAA || be !== 4'b0011) begin errors++; $display("FAIL part_word got req=%b %h be=%b want 1 0000bbaa 0011", req, wdata, be); end
    gnt = 1'b1; tick(); gnt = 1'b0;
    tests++; if (busy !== 1'b0 || req !== 1'b0 || ws !== 16'd2) begin errors++; $display("FAIL part_after got busy=%b req=%b ws=%0d want 0 0 2", busy, req, ws); end
  endtask

  task automatic test_flush_with_byte();
    put(8'h01); put(8'h02);
    bv = 1'b1; bd = 8'hCC; fl = 1'b1; tick(); bv = 1'b0; fl = 1'b0;
    tests++; if (req !== 1'b1 || wdata !== 32'h00CC0201 || be !== 4'b0111) begin errors++; $display("FAIL fbyte_word got req=%b %h be=%b want 1 00cc0201 0111", req, wdata, be); end
    gnt = 1'b1; tick(); gnt = 1'b0;
    tests++; if (ws !== 16'd3 || busy !== 1'b0) begin errors++; $display("FAIL fbyte_cnt got ws=%0d busy=%b want 3 0", ws, busy); end
  endtask

  task automatic test_stall();
    gnt = 1'b0;
    put(8'h55); put(8'h56); put(8'h57); put(8'h58);
    bv = 1'b1; bd = 8'h99;
    for (int c = 0; c < 10; c++) begin
      tests++; if ({req, ready} !== 2'b10 || wdata !== 32'h58575655 || be !== 4'hF) begin errors++; $display("FAIL stall_c%0d got req=%b rdy=%b %h be=%h want 1 0 58575655 f", c, req, ready, wdata, be); end
      fl = (c == 3); tick();
    end
    fl = 1'b0;
    tests++; if (ws !== 16'd3) begin errors++; $display("FAIL stall_nocnt got %0d want 3", ws); end
    gnt = 1'b1; tick(); gnt = 1'b0;
    tests++; if (ws !== 16'd4 || ws_n !== 2'd0 || ready !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL stall_gnt got ws=%0d/%0d rdy=%b busy=%b want 4/0 1 0", ws, ws_n, ready, busy); end
    tick(); put(8'h9A); put(8'h9B); put(8'h9C);
    tests++; if (req !== 1'b1 || wdata !== 32'h9C9B9A99) begin errors++; $display("FAIL stall_kept got req=%b %h want 1 9c9b9a99", req, wdata); end
    gnt = 1'b1; tick(); gnt = 1'b0;
    tests++; if (ws !== 16'd5 || ws_n !== 2'd1) begin errors++; $display("FAIL stall_cnt2 got %0d/%0d want 5/1", ws, ws_n); end
  endtask

  task automatic test_wrap();
    gnt = 1'b1;
    for (int k = 0; k < 3; k++) begin
      bv = 1'b1; bd = 8'hE0 + 8'(k); fl = 1'b1; tick(); bv = 1'b0; fl = 1'b0;
      tests++; if (req !== 1'b1 || be !== 4'b0001 || wdata !== (32'hE0 + 32'(k))) begin errors++; $display("FAIL wrap_w%0d got req=%b be=%b %h want 1 0001 %h", k, req, be, wdata, 32'hE0 + 32'(k)); end
      tick();
    end
    tests++; if (ws !== 16'd8 || ws_n !== 2'd0) begin errors++; $display("FAIL wrap_cnt got %0d/%0d want 8/0", ws, ws_n); end
    fl = 1'b1; tick(); fl = 1'b0;
    tests++; if (req !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL flush_idle got req=%b busy=%b want 0 0", req, busy); end
    tick();
    tests++; if (ws !== 16'd8) begin errors++; $display("FAIL flush_idle_cnt got %0d want 8", ws); end
  endtask

  task automatic test_reset_mid_req();
    gnt = 1'b0;
    put(8'h10); put(8'h20); put(8'h30); put(8'h40);
    rst_n = 1'b0; #2;
    tests++; if (req !== 1'b1 || ws !== 16'd8 || be !== 4'hF) begin errors++; $display("FAIL rst_async got req=%b ws=%0d be=%h want 1 8 f", req, ws, be); end
    tick(); rst_n = 1'b1;
    tests++; if ({req, ready, busy} !== 3'b010 || be !== 4'h0 || wdata !== 32'h0) begin errors++; $display("FAIL rst_req got req=%b rdy=%b busy=%b be=%h %h want 0 1 0 0 0", req, ready, busy, be, wdata); end
    tests++; if (ws !== 16'd0 || ws_n !== 2'd0) begin errors++; $display("FAIL rst_cnt got %0d/%0d want 0/0", ws, ws_n); end
  endtask

  initial begin
    test_reset();
    test_full_word();
    test_flush_partial();
    test_flush_with_byte();
    test_stall();
    test_wrap();
    test_reset_mid_req();
    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

endmodule
